uart_rx_stream: RTL and testbench

UART_RX_STREAM -- requirements
Module: uart_rx_stream

---
 rtl/c2_uart_pkg.sv | 16 +
 rtl/uart_rx_stream_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_stream.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_stream.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c2_uart_pkg.sv
// c2_uart_pkg: shared receiver state type and constants.
// Imported by every file of the uart_rx_stream slice.
package c2_uart_pkg;

    localparam int DATA_W = 8;
    localparam int CLK_DIV_DEFAULT = 217;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_stream_if.sv
// uart_rx_stream_if: valid/ready byte stream leaving the receiver.
interface uart_rx_stream_if;
    import c2_uart_pkg::*;

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through byte FIFO.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo
    import c2_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on a full FIFO frees the slot the push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver with a valid/ready byte output.
// Define C2_UART_RX_FIFO_EN to buffer bytes in uart_rx_fifo.
module uart_rx_stream
    import c2_uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    uart_rx_stream_if.master stream,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_W - 1);

    logic              rx_meta;
    logic              rx_sync;
    logic [1:0]        warm;
    logic              armed;
    rx_state_t         state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shift;
    logic              byte_done;

    // armed = previous synchronized sample was a real 1, not the preset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            warm    <= '0;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            warm    <= {warm[0], 1'b1};
            armed   <= warm[1] & rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (armed && !rx_sync) begin
                        state <= ST_START;
                        cnt   <= HALF_RELOAD;
                    end
                end
                ST_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_sync) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_DATA;
                        cnt     <= BIT_RELOAD;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift   <= {rx_sync, shift[DATA_W-1:1]};
                        cnt     <= BIT_RELOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_sync) begin
                        byte_done <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef C2_UART_RX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;

    logic full;
    logic empty;

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (byte_done),
        .push_data(shift),
        .pop      (stream.ready),
        .head     (stream.data),
        .full     (full),
        .empty    (empty)
    );

    assign stream.valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= byte_done && full && !stream.ready;
        end
    end
`else
    localparam bit FIFO_EN = 1'b0;

    // A byte landing on the cycle of a transfer replaces the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            stream.data  <= '0;
            stream.valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_done) begin
                if (!stream.valid || stream.ready) begin
                    stream.data  <= shift;
                    stream.valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (stream.valid && stream.ready) begin
                stream.valid <= 1'b0;
            end
        end
    end
`endif

    if (FIFO_EN && (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_stream: FIFO_DEPTH must be a power of two in 2..16");
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: scenario tasks against a byte-level receive model.
// Works with or without C2_UART_RX_FIFO_EN defined.
module tb_uart_rx_stream;
    import c2_uart_pkg::*;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int PER   = 10;
`ifdef C2_UART_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic frame_err;
    logic overrun;

    uart_rx_stream_if s ();

    uart_rx_stream #(
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .stream   (s),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #(PER / 2) clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_q [$];
    int  fe_cnt   = 0;
    int  ov_cnt   = 0;
    int  both_cnt = 0;
    int  rise_cnt = 0;
    time t_rise   = 0;
    time t_mid    = 0;
    logic valid_d = 1'b0;

    // Inputs change 1 time unit after posedge, so negedge sees the
    // exact values the next posedge will act on.
    always @(negedge clk) begin
        if (s.valid === 1'b1 && s.ready === 1'b1) got_q.push_back(s.data);
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
        if (frame_err === 1'b1 && overrun === 1'b1) both_cnt <= both_cnt + 1;
        if (s.valid === 1'b1 && !valid_d) begin
            rise_cnt <= rise_cnt + 1;
            t_rise   <= $time;
        end
        valid_d <= (s.valid === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(DIV);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rx = stop;
        tick(DIV / 2);
        t_mid = $time;
        tick(DIV - DIV / 2);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s.ready = 1'b0;
        rx = 1'b1;
        tick(3);
        checks++;
        if (s.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", s.valid);
        end
        checks++;
        if (s.data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got=%h exp=00", s.data);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got=%b%b exp=00", frame_err, overrun);
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic;
        int n0, r0;
        s.ready = 1'b1;
        n0 = got_q.size();
        r0 = rise_cnt;
        send_byte(8'hA5, 1'b1);
        tick(8);
        checks++;
        if (got_q.size() - n0 != 1) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=1", got_q.size() - n0);
        end else begin
            checks++;
            if (got_q[n0] !== 8'hA5) begin
                errors++;
                $display("FAIL basic_data got=%h exp=a5", got_q[n0]);
            end
        end
        checks++;
        if (rise_cnt - r0 != 1) begin
            errors++;
            $display("FAIL basic_valid_pulses got=%0d exp=1", rise_cnt - r0);
        end
        checks++;
        if (!(t_rise > t_mid && t_rise - t_mid <= 4 * PER + PER / 2)) begin
            errors++;
            $display("FAIL basic_latency got=%0t exp<=%0t", t_rise - t_mid,
                     4 * PER + PER / 2);
        end
    endtask

    task automatic test_false_start;
        int n0, r0, f0;
        s.ready = 1'b1;
        n0 = got_q.size();
        r0 = rise_cnt;
        f0 = fe_cnt;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        checks++;
        if (rise_cnt != r0 || got_q.size() != n0) begin
            errors++;
            $display("FAIL false_start_valid got=%0d exp=0", rise_cnt - r0);
        end
        checks++;
        if (fe_cnt != f0) begin
            errors++;
            $display("FAIL false_start_ferr got=%0d exp=0", fe_cnt - f0);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL false_start_state got=%0d exp=%0d", dut.state, ST_IDLE);
        end
    endtask

    task automatic test_frame_error;
        int n0, f0, o0;
        s.ready = 1'b1;
        n0 = got_q.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(2 * DIV);
        send_byte(8'h11, 1'b1);
        tick(8);
        checks++;
        if (fe_cnt - f0 != 1) begin
            errors++;
            $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - f0);
        end
        checks++;
        if (got_q.size() - n0 != 1) begin
            errors++;
            $display("FAIL frame_count got=%0d exp=1", got_q.size() - n0);
        end else begin
            checks++;
            if (got_q[n0] !== 8'h11) begin
                errors++;
                $display("FAIL frame_next_byte got=%h exp=11", got_q[n0]);
            end
        end
        checks++;
        if (ov_cnt != o0) begin
            errors++;
            $display("FAIL frame_overrun got=%0d exp=0", ov_cnt - o0);
        end
    endtask

    task automatic test_overrun;
        int n0, o0;
        logic [7:0] base;
        logic [7:0] exp_b;
        base = (CAP == 1) ? 8'h01 : 8'h10;
        s.ready = 1'b0;
        tick(2);
        n0 = got_q.size();
        o0 = ov_cnt;
        for (int i = 0; i < CAP; i++) begin
            send_byte(base + 8'(i), 1'b1);
            tick(2);
        end
        tick(6);
        checks++;
        if (ov_cnt != o0) begin
            errors++;
            $display("FAIL overrun_early got=%0d exp=0", ov_cnt - o0);
        end
        send_byte(base + 8'(CAP), 1'b1);
        tick(8);
        checks++;
        if (ov_cnt - o0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses got=%0d exp=1", ov_cnt - o0);
        end
        checks++;
        if (s.valid !== 1'b1 || s.data !== base) begin
            errors++;
            $display("FAIL overrun_held got=%b/%h exp=1/%h", s.valid, s.data, base);
        end
        s.ready = 1'b1;
        tick(4 * CAP + 4);
        checks++;
        if (got_q.size() - n0 != CAP) begin
            errors++;
            $display("FAIL overrun_drain got=%0d exp=%0d", got_q.size() - n0, CAP);
        end
        for (int i = 0; i < CAP; i++) begin
            exp_b = base + 8'(i);
            checks++;
            if (n0 + i >= got_q.size()) begin
                errors++;
                $display("FAIL overrun_order[%0d] got=none exp=%h", i, exp_b);
            end else if (got_q[n0 + i] !== exp_b) begin
                errors++;
                $display("FAIL overrun_order[%0d] got=%h exp=%h", i,
                         got_q[n0 + i], exp_b);
            end
        end
        checks++;
        if (s.valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_empty got=%b exp=0", s.valid);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n0;
        s.ready = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        checks++;
        if (s.valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid got=%b exp=0", s.valid);
        end
        rx = 1'b1;
        tick(3 * DIV);
        rst = 1'b0;
        tick(2 * DIV);
        n0 = got_q.size();
        send_byte(8'h66, 1'b1);
        tick(8);
        checks++;
        if (got_q.size() - n0 != 1) begin
            errors++;
            $display("FAIL rst_mid_count got=%0d exp=1", got_q.size() - n0);
        end else begin
            checks++;
            if (got_q[n0] !== 8'h66) begin
                errors++;
                $display("FAIL rst_mid_data got=%h exp=66", got_q[n0]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        int n0, f0, o0, fe_exp;
        logic bad;
        s.ready = 1'b1;
        n0 = got_q.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        fe_exp = 0;
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_byte(b, !bad);
            if (bad) begin
                fe_exp++;
                rx = 1'b0;
                tick($urandom_range(0, 10));
                rx = 1'b1;
                tick(2 * DIV);
            end else begin
                exp_q.push_back(b);
            end
            tick($urandom_range(0, 3));
        end
        tick(8);
        checks++;
        if (got_q.size() - n0 != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got=%0d exp=%0d", got_q.size() - n0,
                     exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (n0 + i >= got_q.size()) begin
                errors++;
                $display("FAIL random_byte[%0d] got=none exp=%h", i, exp_q[i]);
            end else if (got_q[n0 + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_byte[%0d] got=%h exp=%h", i,
                         got_q[n0 + i], exp_q[i]);
            end
        end
        checks++;
        if (fe_cnt - f0 != fe_exp) begin
            errors++;
            $display("FAIL random_ferr got=%0d exp=%0d", fe_cnt - f0, fe_exp);
        end
        checks++;
        if (ov_cnt != o0) begin
            errors++;
            $display("FAIL random_overrun got=%0d exp=0", ov_cnt - o0);
        end
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL err_exclusive got=%0d exp=0", both_cnt);
        end
    endtask

    initial begin
        #(PER * 50000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s.ready = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
